// File: rtl/tach_pkg.sv
// Shared types for the tachometer / encoder-emulator path.
// The quadrature enum encoding is literally {A,B}, so channel outputs are plain bit selects.
package tach_pkg;

    typedef enum logic [1:0] {
        Q00 = 2'b00,
        Q10 = 2'b10,
        Q11 = 2'b11,
        Q01 = 2'b01
    } quad_state_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_state_t;

    localparam int MIN_PERIOD_DEFAULT = 2;

endpackage

// File: rtl/quad_sequencer.sv
// Combinational quadrature step: next {A,B} for a given direction, and whether
// that step raises channel A.
module quad_sequencer
    import tach_pkg::*;
(
    input  quad_state_t i_state,
    input  logic        i_dir,
    output quad_state_t o_next,
    output logic        o_a_rise
);

    always_comb begin
        o_next = Q00;
        if (!i_dir) begin
            case (i_state)
                Q00:     o_next = Q10;
                Q10:     o_next = Q11;
                Q11:     o_next = Q01;
                default: o_next = Q00;
            endcase
        end else begin
            case (i_state)
                Q00:     o_next = Q01;
                Q01:     o_next = Q11;
                Q11:     o_next = Q10;
                default: o_next = Q00;
            endcase
        end
    end

    assign o_a_rise = o_next[1] & ~i_state[1];

endmodule

// File: rtl/encoder_emulator.sv
// Quadrature encoder emulator: generates A/B steps every programmed period in the
// chosen direction and counts rising edges of A.
module encoder_emulator
    import tach_pkg::*;
#(
    parameter int COUNT_WIDTH = 32,
    parameter int MIN_PERIOD  = MIN_PERIOD_DEFAULT
)(
    input  logic                   clock,
    input  logic                   system_reset,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [COUNT_WIDTH-1:0] period_in,
    input  logic                   dir_in,
    input  logic                   clear_count,
    output logic                   encoder_a,
    output logic                   encoder_b,
    output logic                   running,
    output logic [COUNT_WIDTH-1:0] pulse_count,
    output fsm_state_t             dbg_state
);

    localparam logic [COUNT_WIDTH-1:0] ONE   = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] MIN_P = COUNT_WIDTH'(MIN_PERIOD);

    fsm_state_t              r_state;
    fsm_state_t              w_state_next;
    quad_state_t             r_quad;
    quad_state_t             w_quad_next;
    logic                    w_a_rise;
    logic [COUNT_WIDTH-1:0]  r_step_cnt;
    logic [COUNT_WIDTH-1:0]  r_period;
    logic                    r_dir;
    logic                    r_pend_valid;
    logic [COUNT_WIDTH-1:0]  r_pend_period;
    logic                    r_pend_dir;
    logic [COUNT_WIDTH-1:0]  r_pulse_count;
    logic [COUNT_WIDTH-1:0]  w_pend_clamped;
    logic                    w_step;
    logic                    w_apply;
    logic                    w_accept;

    // cfg handshake: a transfer happens on an edge where cfg_valid && cfg_ready;
    // the offer must stay stable until then. One slot, so ready == slot empty.
    assign cfg_ready = ~r_pend_valid;
    assign w_accept  = cfg_valid & ~r_pend_valid;

    assign w_step  = (r_state == RUN) && (r_step_cnt == r_period - ONE);
    assign w_apply = r_pend_valid && ((r_state == IDLE) || w_step);

    assign w_pend_clamped = ((r_pend_period != '0) && (r_pend_period < MIN_P)) ? MIN_P
                                                                               : r_pend_period;

    // Sequencer sees the current direction, so a step coinciding with an apply uses the old one.
    quad_sequencer u_seq (
        .i_state  (r_quad),
        .i_dir    (r_dir),
        .o_next   (w_quad_next),
        .o_a_rise (w_a_rise)
    );

    always_ff @(posedge clock or posedge system_reset) begin
        if (system_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_apply) begin
            w_state_next = (r_pend_period == '0) ? IDLE : RUN;
        end
    end

    always_ff @(posedge clock or posedge system_reset) begin
        if (system_reset) begin
            r_quad        <= Q00;
            r_step_cnt    <= '0;
            r_period      <= '0;
            r_dir         <= 1'b0;
            r_pend_valid  <= 1'b0;
            r_pend_period <= '0;
            r_pend_dir    <= 1'b0;
            r_pulse_count <= '0;
        end else begin
            if (w_accept) begin
                r_pend_valid  <= 1'b1;
                r_pend_period <= period_in;
                r_pend_dir    <= dir_in;
            end else if (w_apply) begin
                r_pend_valid  <= 1'b0;
            end

            if (w_apply) begin
                r_step_cnt <= '0;
                r_period   <= w_pend_clamped;
                r_dir      <= r_pend_dir;
            end else if (r_state == RUN) begin
                r_step_cnt <= w_step ? '0 : r_step_cnt + ONE;
            end

            if (w_step) begin
                r_quad <= w_quad_next;
            end

            if (clear_count) begin
                r_pulse_count <= '0;
            end else if (w_step && w_a_rise) begin
                r_pulse_count <= r_pulse_count + ONE;
            end
        end
    end

    assign encoder_a   = r_quad[1];
    assign encoder_b   = r_quad[0];
    assign running     = (r_state == RUN);
    assign pulse_count = r_pulse_count;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_encoder_emulator.sv
// Self-checking bench for encoder_emulator (8-bit counter build): a timeline reference
// model schedules expected steps, a monitor checks levels every cycle and pops step events.
module tb_encoder_emulator;
    import tach_pkg::*;

    localparam int CW   = 8;
    localparam int EW   = 32 + 2 + CW;
    localparam int MINP = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [CW-1:0] period_in;
    logic          dir_in;
    logic          clear_count;
    logic          encoder_a;
    logic          encoder_b;
    logic          running;
    logic [CW-1:0] pulse_count;
    fsm_state_t    dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [EW-1:0] exp_q[$];

    encoder_emulator #(.COUNT_WIDTH(CW)) dut (
        .clock        (clk),
        .system_reset (rst),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .period_in    (period_in),
        .dir_in       (dir_in),
        .clear_count  (clear_count),
        .encoder_a    (encoder_a),
        .encoder_b    (encoder_b),
        .running      (running),
        .pulse_count  (pulse_count),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic logic [1:0] ab_of(input int ph);
        case (ph)
            1:       return 2'b10;
            2:       return 2'b11;
            3:       return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s timed out at %0t", name, $time);
    endtask

    // ---------------- reference model ----------------
    // Position is a phase index 0..3 around the (A,B) cycle; steps are scheduled by
    // absolute cycle number rather than by a counter.
    logic [31:0]   cyc = '0;
    logic          m_running = 1'b0;
    logic [CW-1:0] m_period = '0;
    logic          m_dir = 1'b0;
    logic [31:0]   m_next = '0;
    int            m_phase = 0;
    logic [CW-1:0] m_count = '0;
    logic          m_pend = 1'b0;
    logic [CW-1:0] m_pend_period = '0;
    logic          m_pend_dir = 1'b0;

    always @(posedge clk or posedge rst) begin
        logic step, apply, accept, old_a, new_a;
        if (rst) begin
            m_running = 1'b0;
            m_period  = '0;
            m_dir     = 1'b0;
            m_next    = '0;
            m_phase   = 0;
            m_count   = '0;
            m_pend    = 1'b0;
            exp_q.delete();
        end else begin
            cyc    = cyc + 32'd1;
            step   = m_running && (cyc == m_next);
            apply  = m_pend && (!m_running || step);
            accept = cfg_valid && !m_pend;
            if (step) begin
                old_a   = ab_of(m_phase)[1];
                m_phase = m_dir ? (m_phase + 3) % 4 : (m_phase + 1) % 4;
                new_a   = ab_of(m_phase)[1];
                if (!old_a && new_a) m_count = m_count + 8'd1;
            end
            if (clear_count) m_count = '0;
            if (step) exp_q.push_back({cyc, ab_of(m_phase), m_count});
            if (apply) begin
                m_dir = m_pend_dir;
                if (m_pend_period == '0) begin
                    m_running = 1'b0;
                end else begin
                    m_running = 1'b1;
                    m_period  = (m_pend_period < CW'(MINP)) ? CW'(MINP) : m_pend_period;
                    m_next    = cyc + 32'(m_period);
                end
                m_pend = 1'b0;
            end else if (step) begin
                m_next = cyc + 32'(m_period);
            end
            if (accept) begin
                m_pend        = 1'b1;
                m_pend_period = period_in;
                m_pend_dir    = dir_in;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [1:0] prev_ab = 2'b00;

    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (rst) begin
            prev_ab = 2'b00;
        end else begin
            chk("running", running, m_running);
            chk("cfg_ready", cfg_ready, !m_pend);
            chk("pulse_count", pulse_count, m_count);
            chk("ab_level", {encoder_a, encoder_b}, ab_of(m_phase));
            if ({encoder_a, encoder_b} != prev_ab) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL step_event unexpected ab=%b count=%0h at %0t",
                             {encoder_a, encoder_b}, pulse_count, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("step_cycle", cyc, e[EW-1:CW+2]);
                    chk("step_ab", {encoder_a, encoder_b}, e[CW+1:CW]);
                    chk("step_count", pulse_count, e[CW-1:0]);
                end
                prev_ab = {encoder_a, encoder_b};
            end
        end
    end

    // ---------------- driver ----------------
    task automatic send_cfg(input logic [CW-1:0] p, input logic d);
        int   waited;
        logic rdy;
        waited = 0;
        @(negedge clk);
        cfg_valid = 1'b1;
        period_in = p;
        dir_in    = d;
        forever begin
            rdy = cfg_ready;
            @(posedge clk);
            if (rdy) break;
            waited++;
            if (waited > 100) begin
                fail_timeout("cfg_accept");
                break;
            end
            @(negedge clk);
        end
        #1 cfg_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n, input int clr_odds);
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            clear_count = (clr_odds > 0) ? ($urandom_range(0, clr_odds - 1) == 0) : 1'b0;
        end
        @(negedge clk);
        clear_count = 1'b0;
    endtask

    initial begin
        int waited;
        rst         = 1'b1;
        cfg_valid   = 1'b0;
        period_in   = '0;
        dir_in      = 1'b0;
        clear_count = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state held with no configuration
        @(negedge clk);
        chk("rst_a", encoder_a, 1'b0);
        chk("rst_b", encoder_b, 1'b0);
        chk("rst_count", pulse_count, 8'h00);
        chk("rst_running", running, 1'b0);
        chk("rst_ready", cfg_ready, 1'b1);
        repeat (100) @(negedge clk);

        // Forward at period 4: first step 4 cycles after apply, 3 A rises after 9 steps
        send_cfg(8'd4, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("fwd_first_count", pulse_count, 8'd1);
        chk("fwd_first_ab", {encoder_a, encoder_b}, 2'b10);
        repeat (32) @(posedge clk);
        @(negedge clk);
        chk("fwd_9steps_count", pulse_count, 8'd3);
        chk("fwd_9steps_ab", {encoder_a, encoder_b}, 2'b10);

        // Reverse while running: slot stays busy until the next step boundary
        send_cfg(8'd4, 1'b1);
        @(negedge clk);
        chk("rev_ready_low", cfg_ready, 1'b0);
        idle_cycles(40, 0);

        // Period 1 clamps to 2, then period 0 stops with A/B held
        send_cfg(8'd1, 1'b0);
        idle_cycles(30, 0);
        send_cfg(8'd0, 1'b0);
        idle_cycles(20, 0);
        chk("stop_running", running, 1'b0);

        // Randomized configurations with occasional clears
        for (int k = 0; k < 10; k++) begin
            send_cfg(CW'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
            idle_cycles($urandom_range(10, 60), 12);
        end

        // Counter wrap at 0xFF, then clears overlapping A rises
        send_cfg(8'd2, 1'b0);
        @(negedge clk);
        clear_count = 1'b1;
        @(negedge clk);
        clear_count = 1'b0;
        waited = 0;
        while (pulse_count != 8'hFF && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 3000) fail_timeout("wrap_reach_ff");
        waited = 0;
        while (pulse_count == 8'hFF && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("wrap_to_zero", pulse_count, 8'h00);
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            clear_count = 1'b1;
        end
        @(negedge clk);
        chk("clear_wins", pulse_count, 8'h00);
        clear_count = 1'b0;

        // Asynchronous reset mid-run with a configuration pending
        send_cfg(8'd6, 1'b0);
        repeat (10) @(negedge clk);
        send_cfg(8'd3, 1'b1);
        @(negedge clk);
        chk("pend_before_rst", cfg_ready, 1'b0);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_a", encoder_a, 1'b0);
        chk("async_rst_b", encoder_b, 1'b0);
        chk("async_rst_count", pulse_count, 8'h00);
        chk("async_rst_running", running, 1'b0);
        chk("async_rst_ready", cfg_ready, 1'b1);
        @(negedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", cfg_ready, 1'b1);
        chk("post_rst_running", running, 1'b0);
        repeat (20) @(negedge clk);

        // One more run after reset, then stop and drain
        send_cfg(8'd3, 1'b1);
        idle_cycles(40, 0);
        send_cfg(8'd0, 1'b0);
        repeat (10) @(negedge clk);
        chk("queue_drain", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
